// File: rtl/dncnt_pkg.sv
// Shared state encoding for the loadable down-counting timer.
package dncnt_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/dncnt_timer.sv
// Loadable down-counting timer: counts a host-loaded value to zero, pulses done,
// and optionally reloads for periodic ticks.
//   state   | meaning
//   IDLE    | waiting for a load; o_load_rdy high
//   RUN     | counting down; o_busy high
module dncnt_timer
    import dncnt_pkg::*;
#(
    parameter  int UPBND = 32,
    localparam int CW    = $clog2(UPBND + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load_vld,
    output logic          o_load_rdy,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_auto_reload,
    input  logic          i_pause,
    input  logic          i_abort,
    output logic [CW-1:0] o_cnt,
    output logic          o_busy,
    output logic          o_done
);

    localparam logic [CW-1:0] MAX_VAL = CW'(UPBND);

    logic          r_state;
    logic          w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_reload;
    logic          r_auto;
    logic          r_done;
    logic [CW-1:0] w_load_v;
    logic          w_accept;
    logic          w_cnt_is_one;

    always_comb begin
        w_load_v = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;
    end

    assign w_accept     = i_load_vld && (r_state == ST_IDLE);
    assign w_cnt_is_one = (r_cnt == CW'(1));

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_load_v != '0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!i_pause && w_cnt_is_one && !r_auto) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_load_rdy = (r_state == ST_IDLE);
        o_busy     = (r_state == ST_RUN);
    end

    // Decrement only above one, so the count can never underflow.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_cnt    <= '0;
            r_reload <= '0;
            r_auto   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_load_v == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cnt    <= w_load_v;
                            r_reload <= w_load_v;
                            r_auto   <= i_auto_reload;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_cnt <= '0;
                    end else if (!i_pause) begin
                        if (r_cnt > CW'(1)) begin
                            r_cnt <= r_cnt - CW'(1);
                        end else if (w_cnt_is_one) begin
                            r_done <= 1'b1;
                            r_cnt  <= r_auto ? r_reload : '0;
                        end
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule
